cpu_checker_fsm: RTL and testbench

Character-stream checker for CPU trace lines. One ASCII character arrives per clock; the block parses register-write and memory-write records of the form `^time@pc: $grf <= data#` or `^time@pc: *addr <= data#`. At the end of each well-formed record it reports the record type and a 4-bit semantic error code. It sits beside the CPU trace output in the test harness, driven by a per-cycle character source.

---
 rtl/cpu_checker_pkg.sv | 18 +
 rtl/cpu_checker_fsm_char_class.sv | 26 ++
 rtl/cpu_checker_fsm.sv | 187 ++++++++++++++++++
 tb/tb_cpu_checker_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cpu_checker_pkg.sv
// Shared types and limits for the CPU trace-line checker.
package cpu_checker_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_GRF, S_ADDR,
        S_SP2, S_LT, S_EQ, S_DATA, S_DONE_REG, S_DONE_MEM, S_ERR
    } state_t;

    localparam logic [1:0]  FMT_NONE = 2'b00;
    localparam logic [1:0]  FMT_REG  = 2'b01;
    localparam logic [1:0]  FMT_MEM  = 2'b10;

    localparam logic [31:0] PC_MIN   = 32'h0000_3000;
    localparam logic [31:0] PC_MAX   = 32'h0000_4FFF;
    localparam logic [31:0] ADDR_MAX = 32'h0000_2FFF;
    localparam logic [13:0] GRF_MAX  = 14'd31;

endpackage

// File: rtl/cpu_checker_fsm_char_class.sv
// Combinational ASCII classifier: decimal / hex digit flags and nibble value.
module char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_dec = 1'b0;
        is_hex = 1'b0;
        nibble = 4'd0;
        if (char >= "0" && char <= "9") begin
            is_dec = 1'b1;
            is_hex = 1'b1;
            nibble = 4'(char - "0");
        end else if (char >= "a" && char <= "f") begin
            is_hex = 1'b1;
            nibble = 4'(char - "a" + 8'd10);
        end else if (char >= "A" && char <= "F") begin
            is_hex = 1'b1;
            nibble = 4'(char - "A" + 8'd10);
        end
    end

endmodule

// File: rtl/cpu_checker_fsm.sv
// Parses "^time@pc: $grf <= data#" / "^time@pc: *addr <= data#" one char per clock
// and reports record type plus semantic error flags for one cycle after '#'.
//
// state    | meaning
// IDLE     | waiting for '^'
// TIME     | '^' seen, collecting 1-4 decimal time digits
// AT       | '@' seen, no pc digit yet
// PC       | collecting 8 pc hex digits
// COLON    | ':' seen
// SP1      | spaces before '$' or '*'
// GRF      | collecting 1-4 decimal grf digits
// ADDR     | collecting 8 addr hex digits
// SP2      | spaces before '<'
// LT       | '<' seen
// EQ       | '=' seen, optional spaces before data
// DATA     | collecting 8 data hex digits
// DONE_REG | register record complete, outputs valid
// DONE_MEM | memory record complete, outputs valid
// ERR      | syntax error, wait for '^'
module cpu_checker_fsm
    import cpu_checker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    input  logic [15:0] freq,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code
);

    state_t      state;
    logic [2:0]  cnt;
    logic        full;      // carry out of cnt: eighth hex digit received
    logic        is_mem;
    logic [13:0] time_acc;
    logic [13:0] grf_acc;
    logic [31:0] pc_acc;
    logic [31:0] addr_acc;

    logic        is_dec;
    logic        is_hex;
    logic [3:0]  nib;

    char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nib)
    );

    always_ff @(posedge clk) begin
        if (reset || char == "^") begin
            state    <= reset ? S_IDLE : S_TIME;
            cnt      <= 3'd0;
            full     <= 1'b0;
            is_mem   <= 1'b0;
            time_acc <= 14'd0;
            grf_acc  <= 14'd0;
            pc_acc   <= 32'd0;
            addr_acc <= 32'd0;
        end else begin
            case (state)
                S_IDLE: ;
                S_TIME:
                    if (is_dec && cnt != 3'd4) begin
                        time_acc <= 14'(time_acc * 14'd10 + {10'd0, nib});
                        cnt      <= cnt + 3'd1;
                    end else if (char == "@" && cnt != 3'd0) begin
                        state <= S_AT;
                        cnt   <= 3'd0;
                    end else
                        state <= S_ERR;
                S_AT:
                    if (is_hex) begin
                        pc_acc <= {pc_acc[27:0], nib};
                        cnt    <= 3'd1;
                        state  <= S_PC;
                    end else
                        state <= S_ERR;
                S_PC:
                    if (is_hex && !full) begin
                        pc_acc      <= {pc_acc[27:0], nib};
                        {full, cnt} <= {1'b0, cnt} + 4'd1;
                    end else if (char == ":" && full)
                        state <= S_COLON;
                    else
                        state <= S_ERR;
                S_COLON, S_SP1:
                    if (char == " ")
                        state <= S_SP1;
                    else if (char == "$") begin
                        state  <= S_GRF;
                        cnt    <= 3'd0;
                        is_mem <= 1'b0;
                    end else if (char == "*") begin
                        state  <= S_ADDR;
                        cnt    <= 3'd0;
                        full   <= 1'b0;
                        is_mem <= 1'b1;
                    end else
                        state <= S_ERR;
                S_GRF:
                    if (is_dec && cnt != 3'd4) begin
                        grf_acc <= 14'(grf_acc * 14'd10 + {10'd0, nib});
                        cnt     <= cnt + 3'd1;
                    end else if (char == " " && cnt != 3'd0)
                        state <= S_SP2;
                    else if (char == "<" && cnt != 3'd0)
                        state <= S_LT;
                    else
                        state <= S_ERR;
                S_ADDR:
                    if (is_hex && !full) begin
                        addr_acc    <= {addr_acc[27:0], nib};
                        {full, cnt} <= {1'b0, cnt} + 4'd1;
                    end else if (char == " " && full)
                        state <= S_SP2;
                    else if (char == "<" && full)
                        state <= S_LT;
                    else
                        state <= S_ERR;
                S_SP2:
                    if (char == " ")
                        state <= S_SP2;
                    else if (char == "<")
                        state <= S_LT;
                    else
                        state <= S_ERR;
                S_LT:
                    if (char == "=") begin
                        state <= S_EQ;
                        cnt   <= 3'd0;
                        full  <= 1'b0;
                    end else
                        state <= S_ERR;
                S_EQ:
                    if (char == " ")
                        state <= S_EQ;
                    else if (is_hex) begin
                        cnt   <= 3'd1;
                        state <= S_DATA;
                    end else
                        state <= S_ERR;
                S_DATA:
                    if (is_hex && !full)
                        {full, cnt} <= {1'b0, cnt} + 4'd1;
                    else if (char == "#" && full)
                        state <= is_mem ? S_DONE_MEM : S_DONE_REG;
                    else
                        state <= S_ERR;
                S_DONE_REG, S_DONE_MEM:
                    state <= S_IDLE;
                S_ERR: ;
                default:
                    state <= S_ERR;
            endcase
        end
    end

    logic [15:0] time_mask;
    logic        time_bad;
    logic        pc_bad;
    logic        addr_bad;
    logic        grf_bad;

    always_comb begin
        time_mask   = (freq >> 1) - 16'd1;
        time_bad    = ({2'b00, time_acc} & time_mask) != 16'd0;
        pc_bad      = (pc_acc < PC_MIN) || (pc_acc > PC_MAX) || (pc_acc[1:0] != 2'b00);
        addr_bad    = (addr_acc > ADDR_MAX) || (addr_acc[1:0] != 2'b00);
        grf_bad     = grf_acc > GRF_MAX;
        format_type = FMT_NONE;
        error_code  = 4'b0000;
        case (state)
            S_DONE_REG: begin
                format_type = FMT_REG;
                error_code  = {grf_bad, 1'b0, pc_bad, time_bad};
            end
            S_DONE_MEM: begin
                format_type = FMT_MEM;
                error_code  = {1'b0, addr_bad, pc_bad, time_bad};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_checker_fsm.sv
// Directed-vector bench for cpu_checker_fsm with hand-computed pulse expectations.
module tb_cpu_checker_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;

    int n_checks = 0;
    int n_errors = 0;

    int         n_pulse;
    int         first_idx;
    int         last_idx;
    logic [1:0] first_fmt;
    logic [3:0] first_err;
    logic [1:0] last_fmt;
    logic [3:0] last_err;

    cpu_checker_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char_in),
        .freq        (freq),
        .format_type (format_type),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sends s one char per clock; after each edge records any nonzero output.
    task automatic run_str(input string s);
        n_pulse   = 0;
        first_idx = -1;
        last_idx  = -1;
        first_fmt = 2'b00;
        first_err = 4'b0000;
        last_fmt  = 2'b00;
        last_err  = 4'b0000;
        for (int i = 0; i < s.len(); i++) begin
            char_in = s[i];
            @(posedge clk);
            #1;
            if (format_type != 2'b00 || error_code != 4'b0000) begin
                if (n_pulse == 0) begin
                    first_idx = i;
                    first_fmt = format_type;
                    first_err = error_code;
                end
                n_pulse++;
                last_idx = i;
                last_fmt = format_type;
                last_err = error_code;
            end
        end
    endtask

    task automatic good_rec(input string tag, input string s, input int fmt, input int err);
        run_str({s, "xx"});
        chk({tag, " pulses"}, n_pulse, 1);
        chk({tag, " idx"}, last_idx, s.len() - 1);
        chk({tag, " fmt"}, int'(last_fmt), fmt);
        chk({tag, " err"}, int'(last_err), err);
    endtask

    task automatic bad_rec(input string tag, input string s);
        run_str({s, "xx"});
        chk({tag, " pulses"}, n_pulse, 0);
    endtask

    string r1, r2;

    initial begin
        reset   = 1'b1;
        char_in = "x";
        freq    = 16'd2048;
        @(posedge clk);
        #1;
        chk("reset fmt", int'(format_type), 0);
        chk("reset err", int'(error_code), 0);
        reset = 1'b0;

        bad_rec("pre-caret", "1024@00003000: $05 <= 00000000#");

        good_rec("reg ok", "^1024@00003000: $05 <= 00000000#", 1, 4'b0000);
        good_rec("mem all", "^1025@00002ffe:*00003000<=12345678#", 2, 4'b0111);

        freq = 16'd4;
        good_rec("grf32", "^2@00003004:   $32 <=   0000ABcd#", 1, 4'b1000);
        good_rec("grf31", "^2@00004ffc:$31<=00000000#", 1, 4'b0000);
        good_rec("pc4fff", "^0@00004fff: *00002ffc <= 00000000#", 2, 4'b0010);
        good_rec("time odd", "^3@00003000:$0<=00000000#", 1, 4'b0001);
        good_rec("addr unal", "^8@00005000:*00000001<=ffffffff#", 2, 4'b0110);

        freq = 16'd2048;
        bad_rec("time5", "^12345@00003000: $1<=00000000#");
        bad_rec("pc7", "^1@0000300: $1<=00000000#");
        bad_rec("lt only", "^1@00003000: $1< =00000000#");
        bad_rec("no hash", "^1@00003000: $1<=00000000");
        bad_rec("data9", "^1@00003000: $1<=000000000#");
        bad_rec("no at", "^1000003000: $1<=00000000#");
        bad_rec("grf5", "^1@00003000: $12345<=00000000#");

        good_rec("restart", "^10@00^0@00003000: $1<=00000000#", 1, 4'b0000);

        run_str("^1024@00003000: $05 <=");
        reset = 1'b1;
        char_in = "x";
        @(posedge clk);
        #1;
        chk("midrst fmt", int'(format_type), 0);
        reset = 1'b0;
        bad_rec("post-rst tail", "00000000#");
        good_rec("post-rst rec", "^1024@00003000: $05 <= 00000000#", 1, 4'b0000);

        r1 = "^1024@00003000: $05 <= 00000000#";
        r2 = "^1025@00002ffe:*00003000<=12345678#";
        run_str({r1, r2, "xx"});
        chk("b2b pulses", n_pulse, 2);
        chk("b2b first idx", first_idx, r1.len() - 1);
        chk("b2b first fmt", int'(first_fmt), 1);
        chk("b2b first err", int'(first_err), 0);
        chk("b2b gap", last_idx - first_idx, r2.len());
        chk("b2b second fmt", int'(last_fmt), 2);
        chk("b2b second err", int'(last_err), 4'b0111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
